// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with active-high enable.
// Synchronous active-high reset; out is the only state in the block.
module decoder_3to8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);

  logic [7:0] r_out;
  logic [7:0] w_onehot;

  assign w_onehot = 8'h01 << in;

  // Reset wins over enable; a disabled decode drives all lines low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (en) begin
      r_out <= w_onehot;
    end else begin
      r_out <= '0;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: expected words are queued at drive time
// and checked one clock later, along with the at-most-one-hot invariant.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] in;
  logic       en;
  logic [7:0] out;

  int unsigned checks;
  int unsigned failures;
  logic [7:0]  sb[$];

  decoder_3to8 dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .en  (en),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference mapping written out as a table.
  function automatic logic [7:0] ref_decode(input logic r, input logic e, input logic [2:0] sel);
    logic [7:0] v;
    if (r || !e) begin
      v = 8'h00;
    end else begin
      case (sel)
        3'd0: v = 8'h01;
        3'd1: v = 8'h02;
        3'd2: v = 8'h04;
        3'd3: v = 8'h08;
        3'd4: v = 8'h10;
        3'd5: v = 8'h20;
        3'd6: v = 8'h40;
        default: v = 8'h80;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one set of inputs, queue its expected result, check after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] sel);
    logic [7:0] exp;
    @(negedge clk);
    rst = r;
    en  = e;
    in  = sel;
    sb.push_back(ref_decode(r, e, sel));
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check(tag, {24'h0, out}, {24'h0, exp});
    check({tag, "_onehot"}, {31'h0, ($countones(out) <= 1)}, 32'h1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    en  = 1'b1;
    in  = 3'b101;

    // Reset with enable high, then release.
    step("reset0", 1'b1, 1'b1, 3'b101);
    step("reset1", 1'b1, 1'b1, 3'b101);
    step("rst_release", 1'b0, 1'b1, 3'b101);

    // Disabled sweep.
    for (int unsigned i = 0; i < 8; i++) step("disabled", 1'b0, 1'b0, 3'(i));

    // Full enabled sweep, a new code every cycle.
    for (int unsigned i = 0; i < 8; i++) step("sweep", 1'b0, 1'b1, 3'(i));

    // Enable toggle at code 3.
    step("toggle_on", 1'b0, 1'b1, 3'b011);
    step("toggle_off", 1'b0, 1'b0, 3'b011);
    step("toggle_on2", 1'b0, 1'b1, 3'b011);

    // Sweep with a reset pulse at code 6.
    for (int unsigned i = 0; i < 6; i++) step("sweep2", 1'b0, 1'b1, 3'(i));
    step("mid_rst", 1'b1, 1'b1, 3'b110);
    step("after_rst", 1'b0, 1'b1, 3'b111);

    // Random mix, reset asserted rarely.
    for (int unsigned i = 0; i < 40; i++)
      step("random", ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    check("sb_empty", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
